axis_sync_fifo_pkt: RTL and testbench

AXIS_SYNC_FIFO_PKT -- requirements
Module: axis_sync_fifo_pkt

---
 rtl/axis_sync_fifo_pkt.sv | 129 ++++++++++++
 tb/tb_axis_sync_fifo_pkt.sv | 270 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/axis_sync_fifo_pkt.sv
// Synchronous AXI-Stream FIFO with first-word-fall-through output, flush, level flags
// and an optional store-and-forward packet mode gated on tlast.
module axis_sync_fifo_pkt #(
    parameter int unsigned TDATA_WIDTH   = 32,
    parameter int unsigned DEPTH         = 8,
    parameter int unsigned PKT_MODE      = 0,
    parameter int unsigned AFULL_THRESH  = DEPTH - 1,
    parameter int unsigned AEMPTY_THRESH = 1
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           s_tvalid,
    output logic                           s_tready,
    input  logic [TDATA_WIDTH-1:0]         s_tdata,
    input  logic                           s_tlast,
    output logic                           m_tvalid,
    input  logic                           m_tready,
    output logic [TDATA_WIDTH-1:0]         m_tdata,
    output logic                           m_tlast,
    input  logic                           invalidate,
    output logic [$clog2(DEPTH+1)-1:0]     count,
    output logic                           almost_full,
    output logic                           almost_empty
);

    localparam int unsigned CW = $clog2(DEPTH + 1);
    localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    localparam logic [CW-1:0] DepthC  = CW'(DEPTH);
    localparam logic [CW-1:0] AfullC  = CW'(AFULL_THRESH);
    localparam logic [CW-1:0] AemptyC = CW'(AEMPTY_THRESH);
    localparam logic [PW-1:0] LastPtr = PW'(DEPTH - 1);

    logic [TDATA_WIDTH:0] mem_q [DEPTH];
    logic [PW-1:0]        wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]        rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]        count_q, count_d;
    logic [CW-1:0]        pkt_cnt_q, pkt_cnt_d;
    logic                 cut_q, cut_d;

    logic                 push;
    logic                 pop;
    logic [TDATA_WIDTH:0] head;

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == LastPtr) ? '0 : p + 1'b1;
    endfunction

    assign head = mem_q[rd_ptr_q];

    always_comb begin
        s_tready = (count_q < DepthC) && !invalidate;
        m_tvalid = (count_q != '0);
        // Packet mode holds data back until a whole packet is in, unless the FIFO is full
        // or a cut-through release is already in progress for the head packet.
        if (PKT_MODE != 0) begin
            m_tvalid = (count_q != '0) && ((pkt_cnt_q != '0) || (count_q == DepthC) || cut_q);
        end
        m_tdata      = m_tvalid ? head[TDATA_WIDTH-1:0] : '0;
        m_tlast      = m_tvalid ? head[TDATA_WIDTH] : 1'b0;
        count        = count_q;
        almost_full  = (count_q >= AfullC);
        almost_empty = (count_q <= AemptyC);
    end

    assign push = s_tvalid && s_tready && !rst;
    assign pop  = m_tvalid && m_tready && !invalidate && !rst;

    always_comb begin
        wr_ptr_d  = wr_ptr_q;
        rd_ptr_d  = rd_ptr_q;
        count_d   = count_q;
        pkt_cnt_d = pkt_cnt_q;
        cut_d     = cut_q;
        if (invalidate) begin
            wr_ptr_d  = '0;
            rd_ptr_d  = '0;
            count_d   = '0;
            pkt_cnt_d = '0;
            cut_d     = 1'b0;
        end else begin
            if (push) begin
                wr_ptr_d = ptr_inc(wr_ptr_q);
            end
            if (pop) begin
                rd_ptr_d = ptr_inc(rd_ptr_q);
                if (m_tlast) begin
                    cut_d = 1'b0;
                end else if (pkt_cnt_q == '0) begin
                    cut_d = 1'b1;
                end
            end
            unique case ({push, pop})
                2'b10:   count_d = count_q + 1'b1;
                2'b01:   count_d = count_q - 1'b1;
                default: count_d = count_q;
            endcase
            unique case ({push && s_tlast, pop && m_tlast})
                2'b10:   pkt_cnt_d = pkt_cnt_q + 1'b1;
                2'b01:   pkt_cnt_d = pkt_cnt_q - 1'b1;
                default: pkt_cnt_d = pkt_cnt_q;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            count_q   <= '0;
            pkt_cnt_q <= '0;
            cut_q     <= 1'b0;
        end else begin
            wr_ptr_q  <= wr_ptr_d;
            rd_ptr_q  <= rd_ptr_d;
            count_q   <= count_d;
            pkt_cnt_q <= pkt_cnt_d;
            cut_q     <= cut_d;
        end
    end

    // Storage needs no reset: m_tdata is masked whenever nothing valid is at the head.
    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_ptr_q] <= {s_tlast, s_tdata};
        end
    end

endmodule

// File: tb/tb_axis_sync_fifo_pkt.sv
// Bench for axis_sync_fifo_pkt: four instances (DEPTH 5/3/8/4, packet mode on the last two),
// a per-instance data scoreboard plus a vector table and directed corner sequences.
module tb_axis_sync_fifo_pkt;

    localparam int N = 4;
    localparam logic H = 1'b1;
    localparam logic L = 1'b0;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst        [N];
    logic       s_tvalid   [N];
    logic       s_tready   [N];
    logic [7:0] s_tdata    [N];
    logic       s_tlast    [N];
    logic       m_tvalid   [N];
    logic       m_tready   [N];
    logic [7:0] m_tdata    [N];
    logic       m_tlast    [N];
    logic       invalidate [N];
    logic [3:0] cnt        [N];
    logic       af         [N];
    logic       ae         [N];

    int n_total = 0;
    int n_pass  = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, want 0x%0h", nm, act, exp);
    endtask

    for (genvar g = 0; g < N; g++) begin : g_dut
        localparam int unsigned D = (g == 0) ? 5 : (g == 1) ? 3 : (g == 2) ? 8 : 4;
        localparam int unsigned P = (g >= 2) ? 1 : 0;
        logic [$clog2(D+1)-1:0] cnt_w;
        logic [8:0] sbq[$];
        logic [8:0] exp_w;

        axis_sync_fifo_pkt #(
            .TDATA_WIDTH(8),
            .DEPTH      (D),
            .PKT_MODE   (P)
        ) u_dut (
            .clk         (clk),
            .rst         (rst[g]),
            .s_tvalid    (s_tvalid[g]),
            .s_tready    (s_tready[g]),
            .s_tdata     (s_tdata[g]),
            .s_tlast     (s_tlast[g]),
            .m_tvalid    (m_tvalid[g]),
            .m_tready    (m_tready[g]),
            .m_tdata     (m_tdata[g]),
            .m_tlast     (m_tlast[g]),
            .invalidate  (invalidate[g]),
            .count       (cnt_w),
            .almost_full (af[g]),
            .almost_empty(ae[g])
        );
        assign cnt[g] = 4'(cnt_w);

        // Scoreboard: accepted words queued, popped words checked in order with tlast.
        always @(negedge clk) begin
            if (rst[g] || invalidate[g]) begin
                sbq.delete();
            end else begin
                if (m_tvalid[g] && m_tready[g]) begin
                    chk($sformatf("sb%0d pop_expected", g), 32'(sbq.size() != 0), 32'd1);
                    if (sbq.size() != 0) begin
                        exp_w = sbq.pop_front();
                        chk($sformatf("sb%0d data", g), 32'({m_tlast[g], m_tdata[g]}),
                            32'(exp_w));
                    end
                end
                if (s_tvalid[g] && s_tready[g]) sbq.push_back({s_tlast[g], s_tdata[g]});
            end
        end
    end

    typedef struct packed {
        logic       sv;
        logic [7:0] sd;
        logic       mr;
        logic       inv;
        logic [3:0] c;
        logic       str;
        logic       mv;
        logic [7:0] md;
        logic       ae;
        logic       af;
    } vec_t;

    function automatic vec_t mk(input logic sv, input logic [7:0] sd, input logic mr,
                                input logic inv, input logic [3:0] c, input logic str,
                                input logic mv, input logic [7:0] md, input logic e,
                                input logic f);
        vec_t v;
        v.sv = sv; v.sd = sd; v.mr = mr; v.inv = inv; v.c = c;
        v.str = str; v.mv = mv; v.md = md; v.ae = e; v.af = f;
        return v;
    endfunction

    task automatic drv(input int g, input logic sv, input logic [7:0] sd, input logic sl,
                       input logic mr, input logic inv);
        s_tvalid[g] = sv; s_tdata[g] = sd; s_tlast[g] = sl;
        m_tready[g] = mr; invalidate[g] = inv;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_reset(input int g, input string tag);
        chk($sformatf("%s s_tready", tag), 32'(s_tready[g]), 32'd1);
        chk($sformatf("%s m_tvalid", tag), 32'(m_tvalid[g]), 32'd0);
        chk($sformatf("%s m_tdata", tag), 32'(m_tdata[g]), 32'd0);
        chk($sformatf("%s m_tlast", tag), 32'(m_tlast[g]), 32'd0);
        chk($sformatf("%s count", tag), 32'(cnt[g]), 32'd0);
        chk($sformatf("%s almost_empty", tag), 32'(ae[g]), 32'd1);
        chk($sformatf("%s almost_full", tag), 32'(af[g]), 32'd0);
    endtask

    vec_t tbl[20];

    initial begin
        // Instance 0: DEPTH=5, AFULL=4, AEMPTY=1. Expectations are pre-edge values.
        tbl[0]  = mk(H, 8'h00, L, L, 4'd0, H, L, 8'h00, H, L);
        tbl[1]  = mk(H, 8'h01, L, L, 4'd1, H, H, 8'h00, H, L);
        tbl[2]  = mk(H, 8'h02, L, L, 4'd2, H, H, 8'h00, L, L);
        tbl[3]  = mk(H, 8'h03, L, L, 4'd3, H, H, 8'h00, L, L);
        tbl[4]  = mk(H, 8'h04, L, L, 4'd4, H, H, 8'h00, L, H);
        tbl[5]  = mk(H, 8'h05, L, L, 4'd5, L, H, 8'h00, L, H);
        tbl[6]  = mk(L, 8'h00, H, L, 4'd5, L, H, 8'h00, L, H);
        tbl[7]  = mk(L, 8'h00, H, L, 4'd4, H, H, 8'h01, L, H);
        tbl[8]  = mk(L, 8'h00, H, L, 4'd3, H, H, 8'h02, L, L);
        tbl[9]  = mk(L, 8'h00, H, L, 4'd2, H, H, 8'h03, L, L);
        tbl[10] = mk(L, 8'h00, H, L, 4'd1, H, H, 8'h04, H, L);
        tbl[11] = mk(L, 8'h00, H, L, 4'd0, H, L, 8'h00, H, L);
        tbl[12] = mk(H, 8'h21, L, L, 4'd0, H, L, 8'h00, H, L);
        tbl[13] = mk(H, 8'h22, L, L, 4'd1, H, H, 8'h21, H, L);
        tbl[14] = mk(H, 8'h23, L, L, 4'd2, H, H, 8'h21, L, L);
        tbl[15] = mk(H, 8'h24, H, H, 4'd3, L, H, 8'h21, L, L);
        tbl[16] = mk(L, 8'h00, H, L, 4'd0, H, L, 8'h00, H, L);
        tbl[17] = mk(H, 8'h99, H, L, 4'd0, H, L, 8'h00, H, L);
        tbl[18] = mk(L, 8'h00, H, L, 4'd1, H, H, 8'h99, H, L);
        tbl[19] = mk(L, 8'h00, H, L, 4'd0, H, L, 8'h00, H, L);

        for (int g = 0; g < N; g++) begin
            rst[g] = H;
            drv(g, L, 8'h00, L, L, L);
        end
        repeat (2) @(posedge clk);
        #1;
        for (int g = 0; g < N; g++) rst[g] = L;
        @(negedge clk);
        for (int g = 0; g < N; g++) chk_reset(g, $sformatf("reset%0d", g));

        // Fill DEPTH=5 past full, drain, then flush with simultaneous push and pop.
        for (int i = 0; i < 20; i++) begin
            step();
            drv(0, tbl[i].sv, tbl[i].sd, L, tbl[i].mr, tbl[i].inv);
            @(negedge clk);
            chk($sformatf("row%0d count", i), 32'(cnt[0]), 32'(tbl[i].c));
            chk($sformatf("row%0d s_tready", i), 32'(s_tready[0]), 32'(tbl[i].str));
            chk($sformatf("row%0d m_tvalid", i), 32'(m_tvalid[0]), 32'(tbl[i].mv));
            chk($sformatf("row%0d almost_empty", i), 32'(ae[0]), 32'(tbl[i].ae));
            chk($sformatf("row%0d almost_full", i), 32'(af[0]), 32'(tbl[i].af));
            if (tbl[i].mv) chk($sformatf("row%0d m_tdata", i), 32'(m_tdata[0]), 32'(tbl[i].md));
        end

        // DEPTH=3 streaming: pointers wrap several times, count holds at 1, no bubbles.
        for (int i = 0; i <= 10; i++) begin
            step();
            drv(1, (i < 10), 8'(8'h10 + i), L, H, L);
            @(negedge clk);
            chk($sformatf("stream%0d m_tvalid", i), 32'(m_tvalid[1]), 32'(i >= 1));
            if (i >= 1 && i <= 10) chk($sformatf("stream%0d count", i), 32'(cnt[1]), 32'd1);
        end
        step();
        drv(1, L, 8'h00, L, L, L);
        @(negedge clk);
        chk("stream_end count", 32'(cnt[1]), 32'd0);

        // Packet mode DEPTH=8: a 3-word packet is held until its tlast is stored.
        for (int k = 0; k <= 6; k++) begin
            step();
            drv(2, (k < 3), 8'(8'h40 + k), (k == 2), H, L);
            @(negedge clk);
            chk($sformatf("pkt%0d m_tvalid", k), 32'(m_tvalid[2]), 32'(k >= 3 && k <= 5));
            chk($sformatf("pkt%0d count", k), 32'(cnt[2]), (k <= 3) ? 32'(k) : 32'(6 - k));
            if (k >= 3 && k <= 5) chk($sformatf("pkt%0d m_tlast", k), 32'(m_tlast[2]),
                                      32'(k == 5));
        end
        step();
        drv(2, L, 8'h00, L, L, L);

        // Packet mode DEPTH=4: full without tlast releases cut-through until tlast drains.
        for (int k = 0; k <= 4; k++) begin
            step();
            drv(3, (k < 4), 8'(8'h50 + k), L, L, L);
            @(negedge clk);
            chk($sformatf("cut_fill%0d m_tvalid", k), 32'(m_tvalid[3]), 32'(k == 4));
            chk($sformatf("cut_fill%0d count", k), 32'(cnt[3]), 32'(k));
            chk($sformatf("cut_fill%0d s_tready", k), 32'(s_tready[3]), 32'(k < 4));
        end
        for (int k = 0; k < 4; k++) begin
            step();
            drv(3, L, 8'h00, L, H, L);
            @(negedge clk);
            chk($sformatf("cut_drain%0d m_tvalid", k), 32'(m_tvalid[3]), 32'd1);
            chk($sformatf("cut_drain%0d count", k), 32'(cnt[3]), 32'(4 - k));
        end
        for (int k = 0; k < 3; k++) begin
            step();
            drv(3, (k == 0), 8'h5F, (k == 0), H, L);
            @(negedge clk);
            chk($sformatf("cut_tail%0d m_tvalid", k), 32'(m_tvalid[3]), 32'(k == 1));
            if (k == 1) chk("cut_tail m_tlast", 32'(m_tlast[3]), 32'd1);
        end
        step();
        drv(3, L, 8'h00, L, L, L);

        // Reset mid-stream at count=2, colliding with invalidate and both handshakes.
        step();
        drv(0, H, 8'h31, L, L, L);
        step();
        drv(0, H, 8'h32, L, L, L);
        step();
        drv(0, H, 8'h33, L, H, H);
        rst[0] = H;
        @(negedge clk);
        chk("midrst pre count", 32'(cnt[0]), 32'd2);
        step();
        rst[0] = L;
        drv(0, L, 8'h00, L, H, L);
        @(negedge clk);
        chk_reset(0, "midrst");
        for (int k = 0; k < 2; k++) begin
            step();
            @(negedge clk);
            chk($sformatf("midrst_idle%0d m_tvalid", k), 32'(m_tvalid[0]), 32'd0);
            chk($sformatf("midrst_idle%0d m_tdata", k), 32'(m_tdata[0]), 32'd0);
        end
        step();
        drv(0, H, 8'h34, L, H, L);
        @(negedge clk);
        chk("midrst_push m_tvalid", 32'(m_tvalid[0]), 32'd0);
        step();
        drv(0, L, 8'h00, L, H, L);
        @(negedge clk);
        chk("midrst_pop m_tvalid", 32'(m_tvalid[0]), 32'd1);
        chk("midrst_pop m_tdata", 32'(m_tdata[0]), 32'h34);
        step();
        drv(0, L, 8'h00, L, L, L);
        @(negedge clk);
        chk("midrst_end count", 32'(cnt[0]), 32'd0);

        chk("sb0 leftover", 32'(g_dut[0].sbq.size()), 32'd0);
        chk("sb1 leftover", 32'(g_dut[1].sbq.size()), 32'd0);
        chk("sb2 leftover", 32'(g_dut[2].sbq.size()), 32'd0);
        chk("sb3 leftover", 32'(g_dut[3].sbq.size()), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
